// File: rtl/regfile_arbiter_if.sv
// Requester and register-file signal bundle for regfile_arbiter.
// a_lock/b_lock exist only when ARB_LOCK_EN is defined.
interface regfile_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              a_req;
  logic              b_req;
  logic              a_we;
  logic              b_we;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [ADDR_W-1:0] a_rs_addr;
  logic [ADDR_W-1:0] b_rs_addr;
  logic [DATA_W-1:0] a_wr_data;
  logic [DATA_W-1:0] b_wr_data;
`ifdef ARB_LOCK_EN
  logic              a_lock;
  logic              b_lock;
`endif
  logic              a_gnt;
  logic              b_gnt;
  logic              a_done;
  logic              b_done;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;
  logic [DATA_W-1:0] a_sdata;
  logic [DATA_W-1:0] b_sdata;
  logic              err;
  logic              rf_rd_en;
  logic              rf_rs_en;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [ADDR_W-1:0] rf_rs_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] rf_rs_data;
  logic              rf_valid;

  modport slave (
    input  a_req, b_req, a_we, b_we,
    input  a_rd_addr, b_rd_addr,
    input  a_rs_addr, b_rs_addr,
    input  a_wr_data, b_wr_data,
`ifdef ARB_LOCK_EN
    input  a_lock, b_lock,
`endif
    input  rf_rd_data, rf_rs_data, rf_valid,
    output a_gnt, b_gnt, a_done, b_done,
    output a_rdata, b_rdata,
    output a_sdata, b_sdata, err,
    output rf_rd_en, rf_rs_en, rf_wr_en,
    output rf_rd_addr, rf_rs_addr, rf_wr_data
  );

  modport master (
    output a_req, b_req, a_we, b_we,
    output a_rd_addr, b_rd_addr,
    output a_rs_addr, b_rs_addr,
    output a_wr_data, b_wr_data,
`ifdef ARB_LOCK_EN
    output a_lock, b_lock,
`endif
    output rf_rd_data, rf_rs_data, rf_valid,
    input  a_gnt, b_gnt, a_done, b_done,
    input  a_rdata, b_rdata,
    input  a_sdata, b_sdata, err,
    input  rf_rd_en, rf_rs_en, rf_wr_en,
    input  rf_rd_addr, rf_rs_addr, rf_wr_data
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin sharing of one register-file port between requesters A and B.
// Define ARB_LOCK_EN to add a_lock/b_lock, keeping priority with a locked winner.
module regfile_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  regfile_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              prio_q, prio_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] a_sdata_q, a_sdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [DATA_W-1:0] b_sdata_q, b_sdata_d;
  logic              rd_en_q, rd_en_d;
  logic              rs_en_q, rs_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              pick;
  logic              lock;
  logic              finish;
  logic [DATA_W-1:0] rdv;
  logic [DATA_W-1:0] rsv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      err_q     <= 1'b0;
      a_rdata_q <= '0;
      a_sdata_q <= '0;
      b_rdata_q <= '0;
      b_sdata_q <= '0;
      rd_en_q   <= 1'b0;
      rs_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rs_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      err_q     <= err_d;
      a_rdata_q <= a_rdata_d;
      a_sdata_q <= a_sdata_d;
      b_rdata_q <= b_rdata_d;
      b_sdata_q <= b_sdata_d;
      rd_en_q   <= rd_en_d;
      rs_en_q   <= rs_en_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rs_addr_q <= rs_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    err_d     = err_q;
    a_rdata_d = a_rdata_q;
    a_sdata_d = a_sdata_q;
    b_rdata_d = b_rdata_q;
    b_sdata_d = b_sdata_q;
    rd_en_d   = 1'b0;
    rs_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rs_addr_d = rs_addr_q;
    wr_data_d = wr_data_q;
    // B wins when alone, or under contention while it holds priority
    pick      = bus.b_req & (~bus.a_req | prio_q);
    finish    = bus.rf_valid | (cnt_q == CW'(TIMEOUT - 1));
    rdv       = bus.rf_valid ? bus.rf_rd_data : '0;
    rsv       = bus.rf_valid ? bus.rf_rs_data : '0;
`ifdef ARB_LOCK_EN
    lock      = win_q ? bus.b_lock : bus.a_lock;
`else
    lock      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.a_req | bus.b_req) begin
          state_d   = S_ISSUE;
          win_d     = pick;
          a_gnt_d   = ~pick;
          b_gnt_d   = pick;
          rd_en_d   = 1'b1;
          rs_en_d   = 1'b1;
          wr_en_d   = pick ? bus.b_we : bus.a_we;
          rd_addr_d = pick ? bus.b_rd_addr : bus.a_rd_addr;
          rs_addr_d = pick ? bus.b_rs_addr : bus.a_rs_addr;
          wr_data_d = pick ? bus.b_wr_data : bus.a_wr_data;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (finish) begin
          state_d  = S_DONE;
          err_d    = ~bus.rf_valid;
          a_done_d = ~win_q;
          b_done_d = win_q;
          if (win_q) begin
            b_rdata_d = rdv;
            b_sdata_d = rsv;
          end else begin
            a_rdata_d = rdv;
            a_sdata_d = rsv;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        prio_d  = lock ? win_q : ~win_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.a_gnt      = a_gnt_q;
  assign bus.b_gnt      = b_gnt_q;
  assign bus.a_done     = a_done_q;
  assign bus.b_done     = b_done_q;
  assign bus.err        = err_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.a_sdata    = a_sdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.b_sdata    = b_sdata_q;
  assign bus.rf_rd_en   = rd_en_q;
  assign bus.rf_rs_en   = rs_en_q;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_rd_addr = rd_addr_q;
  assign bus.rf_rs_addr = rs_addr_q;
  assign bus.rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: randomized transactions against a
// transaction-level model of arbitration, latency, timeout and data capture.
module tb_regfile_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register-file responder state
  int          rf_delay = 1;
  logic [DW-1:0] rsp_rd = '0;
  logic [DW-1:0] rsp_rs = '0;
  bit          pend = 0;
  int          wcnt = 0;
  int          n_wr = 0;
  logic        iss_we;
  logic [AW-1:0] iss_rd, iss_rs;
  logic [DW-1:0] iss_wd;

  // per-transaction observations
  int t_who, t_dwho, t_lat, t_ngnt, t_ndone, t_gcyc;
  bit t_bad;

  // reference model
  bit          m_prio;
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] m_rs [2];

  initial begin
    bus.rf_valid   = 1'b0;
    bus.rf_rd_data = '0;
    bus.rf_rs_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 0;
        bus.rf_valid = 1'b0;
      end else begin
        bus.rf_valid   = 1'b0;
        bus.rf_rd_data = DW'($urandom);
        bus.rf_rs_data = DW'($urandom);
        if (pend) begin
          wcnt++;
          if (wcnt == rf_delay) begin
            bus.rf_valid   = 1'b1;
            bus.rf_rd_data = rsp_rd;
            bus.rf_rs_data = rsp_rs;
            pend = 0;
          end else if (wcnt >= TO) begin
            pend = 0;
          end
        end
        if (bus.rf_rd_en) begin
          pend   = 1;
          wcnt   = 0;
          iss_we = bus.rf_wr_en;
          iss_rd = bus.rf_rd_addr;
          iss_rs = bus.rf_rs_addr;
          iss_wd = bus.rf_wr_data;
        end
        if (bus.rf_wr_en) n_wr++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_pick(bit ra, bit rb);
    if (ra && rb) return m_prio ? 1 : 0;
    return rb ? 1 : 0;
  endfunction

  function automatic int m_lat(int d);
    return 1 + ((d <= TO) ? d : TO);
  endfunction

  task automatic m_done(int w, bit lk);
    m_prio = lk ? (w == 1) : (w == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    m_prio = 0;
    m_rd[0] = '0; m_rd[1] = '0;
    m_rs[0] = '0; m_rs[1] = '0;
    tick();
  endtask

  task automatic txn(input bit ra, input bit rb, input int dly, input bit hold);
    bit seen;
    int gc;
    t_bad = 0; t_who = -1; t_dwho = -1; t_lat = -1;
    t_ngnt = 0; t_ndone = 0; gc = 0; t_gcyc = 0;
    rf_delay = dly;
    bus.a_req = ra;
    bus.b_req = rb;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.a_gnt || bus.b_gnt) begin
        seen = 1;
        t_ngnt++;
        gc = cyc;
        t_gcyc = cyc;
        t_who = (bus.a_gnt && bus.b_gnt) ? 2 : (bus.b_gnt ? 1 : 0);
        if (!hold) begin
          if (bus.a_gnt) bus.a_req = 1'b0;
          if (bus.b_gnt) bus.b_req = 1'b0;
        end
      end
    end
    if (!seen) t_bad = 1;
    seen = t_bad;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.a_gnt || bus.b_gnt) t_ngnt++;
      if (bus.a_done || bus.b_done) begin
        seen = 1;
        t_ndone++;
        t_dwho = (bus.a_done && bus.b_done) ? 2 : (bus.b_done ? 1 : 0);
        t_lat = cyc - gc;
      end
    end
    if (!seen) t_bad = 1;
    if (!hold) begin
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
    end
    tick();
    if (bus.a_gnt || bus.b_gnt) t_ngnt++;
    if (bus.a_done || bus.b_done) t_ndone++;
  endtask

  task automatic test_reset();
    int nd;
    repeat (2) tick();
    vectors++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.err,
         bus.rf_rd_en, bus.rf_rs_en, bus.rf_wr_en} !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got nonzero strobes, want 0");
    end
    vectors++;
    if ({bus.a_rdata, bus.a_sdata, bus.b_rdata, bus.b_sdata, bus.rf_wr_data,
         bus.rf_rd_addr, bus.rf_rs_addr} !== 88'h0) begin
      miscompares++;
      $display("FAIL reset_data: got nonzero data/address, want 0");
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    m_prio = 0;
    bus.a_we = 1'b0; bus.a_rd_addr = 4'h5; bus.a_rs_addr = 4'h6;
    rsp_rd = 16'h1234; rsp_rs = 16'h5678;
    txn(1, 0, 1, 0);
    m_done(0, 0);
    vectors++;
    if (t_bad || t_who !== 0) begin
      miscompares++;
      $display("FAIL reset_first_txn: got who=%0d bad=%0d, want who=0", t_who, t_bad);
    end
    rf_delay = 100;
    bus.b_we = 1'b1; bus.b_rd_addr = 4'h9; bus.b_wr_data = 16'hAAAA;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    tick();
    vectors++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_setup_gnt: got %b, want 01", {bus.a_gnt, bus.b_gnt});
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.err,
         bus.rf_rd_en, bus.rf_rs_en, bus.rf_wr_en} !== 8'h0) begin
      miscompares++;
      $display("FAIL midwait_rst_ctrl: got nonzero strobes, want 0");
    end
    vectors++;
    if ({bus.a_rdata, bus.a_sdata, bus.b_rdata, bus.b_sdata, bus.rf_wr_data,
         bus.rf_rd_addr, bus.rf_rs_addr} !== 88'h0) begin
      miscompares++;
      $display("FAIL midwait_rst_data: got a_rdata=%h rf_wr_data=%h, want 0",
               bus.a_rdata, bus.rf_wr_data);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    m_prio = 0;
    m_rd[0] = '0; m_rd[1] = '0;
    m_rs[0] = '0; m_rs[1] = '0;
    nd = 0;
    repeat (15) begin
      tick();
      if (bus.a_done || bus.b_done) nd++;
    end
    vectors++;
    if (nd !== 0) begin
      miscompares++;
      $display("FAIL midwait_rst_no_done: got %0d dones, want 0", nd);
    end
    rsp_rd = 16'h0101; rsp_rs = 16'h0202;
    txn(1, 1, 1, 0);
    vectors++;
    if (t_bad || t_who !== m_pick(1, 1)) begin
      miscompares++;
      $display("FAIL reset_prio: got who=%0d, want %0d", t_who, m_pick(1, 1));
    end
    m_rd[0] = rsp_rd; m_rs[0] = rsp_rs;
    m_done(0, 0);
  endtask

  task automatic test_write();
    int w;
    bus.a_we = 1'b1; bus.a_rd_addr = 4'h0; bus.a_rs_addr = 4'h3;
    bus.a_wr_data = 16'h00FF;
    rsp_rd = 16'h0BAD; rsp_rs = 16'h1111;
    n_wr = 0;
    w = m_pick(1, 0);
    txn(1, 0, 1, 0);
    vectors++;
    if (t_bad || t_who !== w || t_dwho !== w || t_lat !== m_lat(1)) begin
      miscompares++;
      $display("FAIL write_timing: got who=%0d dwho=%0d lat=%0d, want %0d/%0d/%0d",
               t_who, t_dwho, t_lat, w, w, m_lat(1));
    end
    vectors++;
    if (n_wr !== 1) begin
      miscompares++;
      $display("FAIL write_wr_en_cycles: got %0d, want 1", n_wr);
    end
    vectors++;
    if ({iss_we, iss_rd, iss_rs, iss_wd} !== {1'b1, 4'h0, 4'h3, 16'h00FF}) begin
      miscompares++;
      $display("FAIL write_issue: got we=%b rd=%h rs=%h wd=%h, want 1/0/3/00ff",
               iss_we, iss_rd, iss_rs, iss_wd);
    end
    vectors++;
    if (bus.a_rdata !== 16'h0BAD || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_rdata: got %h err=%b, want 0bad err=0", bus.a_rdata, bus.err);
    end
    m_rd[0] = rsp_rd; m_rs[0] = rsp_rs;
    m_done(w, 0);
  endtask

  task automatic test_read();
    int w;
    bus.a_we = 1'b0; bus.a_rd_addr = 4'h0; bus.a_rs_addr = 4'h1;
    bus.a_wr_data = 16'h7777;
    rsp_rd = 16'h00FF; rsp_rs = 16'hFF00;
    n_wr = 0;
    w = m_pick(1, 0);
    txn(1, 0, 1, 0);
    vectors++;
    if (t_bad || t_dwho !== w || t_lat !== m_lat(1) || n_wr !== 0) begin
      miscompares++;
      $display("FAIL read_timing: got dwho=%0d lat=%0d n_wr=%0d, want %0d/%0d/0",
               t_dwho, t_lat, n_wr, w, m_lat(1));
    end
    vectors++;
    if ({bus.a_rdata, bus.a_sdata, bus.err} !== {16'h00FF, 16'hFF00, 1'b0}) begin
      miscompares++;
      $display("FAIL read_data: got %h/%h err=%b, want 00ff/ff00 err=0",
               bus.a_rdata, bus.a_sdata, bus.err);
    end
    m_rd[0] = rsp_rd; m_rs[0] = rsp_rs;
    m_done(w, 0);
  endtask

  task automatic test_back_to_back();
    int w;
    int prev;
    do_reset();
    bus.a_we = 1'b0; bus.b_we = 1'b0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      rsp_rd = DW'($urandom); rsp_rs = DW'($urandom);
      w = m_pick(1, 1);
      txn(1, 1, 2, 1);
      vectors++;
      if (t_bad || t_who !== w || t_ngnt !== 1 || t_ndone !== 1) begin
        miscompares++;
        $display("FAIL b2b_order[%0d]: got who=%0d gnts=%0d dones=%0d, want who=%0d 1/1",
                 k, t_who, t_ngnt, t_ndone, w);
      end
      if (k > 0) begin
        vectors++;
        if (t_gcyc - prev !== 1 + 2 + 2) begin
          miscompares++;
          $display("FAIL b2b_gap[%0d]: got %0d, want 5", k, t_gcyc - prev);
        end
      end
      prev = t_gcyc;
      m_rd[w] = rsp_rd; m_rs[w] = rsp_rs;
      m_done(w, 0);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    vectors++;
    if ({bus.a_rdata, bus.a_sdata, bus.b_rdata, bus.b_sdata} !==
        {m_rd[0], m_rs[0], m_rd[1], m_rs[1]}) begin
      miscompares++;
      $display("FAIL b2b_data: got %h %h %h %h, want %h %h %h %h",
               bus.a_rdata, bus.a_sdata, bus.b_rdata, bus.b_sdata,
               m_rd[0], m_rs[0], m_rd[1], m_rs[1]);
    end
  endtask

  task automatic test_timeout();
    bus.b_we = 1'b0; bus.b_rd_addr = 4'h2; bus.b_rs_addr = 4'h3;
    rsp_rd = 16'hBEEF; rsp_rs = 16'hCAFE;
    txn(0, 1, 1, 0);
    m_rd[1] = rsp_rd; m_rs[1] = rsp_rs;
    m_done(1, 0);
    vectors++;
    if (bus.b_rdata !== m_rd[1] || bus.b_sdata !== m_rs[1]) begin
      miscompares++;
      $display("FAIL timeout_pre: got %h/%h, want %h/%h",
               bus.b_rdata, bus.b_sdata, m_rd[1], m_rs[1]);
    end
    txn(0, 1, 100, 0);
    vectors++;
    if (t_bad || t_dwho !== 1 || t_lat !== m_lat(100)) begin
      miscompares++;
      $display("FAIL timeout_latency: got dwho=%0d lat=%0d, want 1/%0d",
               t_dwho, t_lat, m_lat(100));
    end
    m_rd[1] = '0; m_rs[1] = '0;
    m_done(1, 0);
    vectors++;
    if ({bus.err, bus.b_rdata, bus.b_sdata} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_err: got err=%b data=%h/%h, want err=1 data=0",
               bus.err, bus.b_rdata, bus.b_sdata);
    end
    vectors++;
    if (bus.a_rdata !== m_rd[0] || bus.a_sdata !== m_rs[0]) begin
      miscompares++;
      $display("FAIL timeout_a_hold: got %h/%h, want %h/%h",
               bus.a_rdata, bus.a_sdata, m_rd[0], m_rs[0]);
    end
    rsp_rd = 16'h4321; rsp_rs = 16'h8765;
    txn(1, 0, 3, 0);
    m_rd[0] = rsp_rd; m_rs[0] = rsp_rs;
    m_done(0, 0);
    vectors++;
    if (bus.err !== 1'b0 || t_lat !== m_lat(3) || bus.a_rdata !== m_rd[0]) begin
      miscompares++;
      $display("FAIL timeout_clear: got err=%b lat=%0d rdata=%h, want 0/%0d/%h",
               bus.err, t_lat, bus.a_rdata, m_lat(3), m_rd[0]);
    end
  endtask

  task automatic test_random();
    int pat, d, w;
    bit ra, rb, tmo;
    logic [AW-1:0] e_rd, e_rs;
    logic [DW-1:0] e_wd;
    logic e_we;
    for (int n = 0; n < 40; n++) begin
      pat = $urandom_range(0, 2);
      ra = (pat != 1);
      rb = (pat != 0);
      d = $urandom_range(1, 11);
      bus.a_we = 1'($urandom); bus.b_we = 1'($urandom);
      bus.a_rd_addr = AW'($urandom); bus.b_rd_addr = AW'($urandom);
      bus.a_rs_addr = AW'($urandom); bus.b_rs_addr = AW'($urandom);
      bus.a_wr_data = DW'($urandom); bus.b_wr_data = DW'($urandom);
      rsp_rd = DW'($urandom); rsp_rs = DW'($urandom);
      w = m_pick(ra, rb);
      tmo = (d > TO);
      e_we = w ? bus.b_we : bus.a_we;
      e_rd = w ? bus.b_rd_addr : bus.a_rd_addr;
      e_rs = w ? bus.b_rs_addr : bus.a_rs_addr;
      e_wd = w ? bus.b_wr_data : bus.a_wr_data;
      txn(ra, rb, d, 0);
      vectors++;
      if (t_bad || t_who !== w || t_dwho !== w || t_lat !== m_lat(d) ||
          t_ngnt !== 1 || t_ndone !== 1) begin
        miscompares++;
        $display("FAIL rand_txn[%0d]: got who=%0d dwho=%0d lat=%0d g=%0d d=%0d, want %0d/%0d/%0d/1/1",
                 n, t_who, t_dwho, t_lat, t_ngnt, t_ndone, w, w, m_lat(d));
      end
      vectors++;
      if ({iss_we, iss_rd, iss_rs, iss_wd} !== {e_we, e_rd, e_rs, e_wd}) begin
        miscompares++;
        $display("FAIL rand_issue[%0d]: got %b %h %h %h, want %b %h %h %h",
                 n, iss_we, iss_rd, iss_rs, iss_wd, e_we, e_rd, e_rs, e_wd);
      end
      m_rd[w] = tmo ? '0 : rsp_rd;
      m_rs[w] = tmo ? '0 : rsp_rs;
      m_done(w, 0);
      vectors++;
      if ({bus.err, bus.a_rdata, bus.a_sdata, bus.b_rdata, bus.b_sdata} !==
          {tmo, m_rd[0], m_rs[0], m_rd[1], m_rs[1]}) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: got err=%b %h %h %h %h, want err=%b %h %h %h %h",
                 n, bus.err, bus.a_rdata, bus.a_sdata, bus.b_rdata, bus.b_sdata,
                 tmo, m_rd[0], m_rs[0], m_rd[1], m_rs[1]);
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int w;
    do_reset();
    bus.a_lock = 1'b1;
    bus.b_lock = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) bus.a_lock = 1'b0;
      rsp_rd = DW'($urandom); rsp_rs = DW'($urandom);
      w = m_pick(1, 1);
      txn(1, 1, 1, 1);
      vectors++;
      if (t_bad || t_who !== w) begin
        miscompares++;
        $display("FAIL lock_order[%0d]: got who=%0d, want %0d", k, t_who, w);
      end
      m_done(w, (w == 0) ? bus.a_lock : bus.b_lock);
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    bus.a_we = 1'b0; bus.b_we = 1'b0;
    bus.a_rd_addr = '0; bus.b_rd_addr = '0;
    bus.a_rs_addr = '0; bus.b_rs_addr = '0;
    bus.a_wr_data = '0; bus.b_wr_data = '0;
`ifdef ARB_LOCK_EN
    bus.a_lock = 1'b0; bus.b_lock = 1'b0;
`endif
    m_prio = 0;
    m_rd[0] = '0; m_rd[1] = '0;
    m_rs[0] = '0; m_rs[1] = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
